fifo_push_arbiter: RTL and testbench

Shares the single push port of one fifo_v3 instance between NUM_REQ producers using valid/ready handshakes. A producer can keep the port for bursts of up to MAX_BURST beats, and arbitration between producers is round-robin. Outputs drive fifo_v3's push_i, data_i and flush_i directly, and the block watches the FIFO's full_o. It sits in the AFU between request sources (e.g. per-channel address samplers) and a shared event queue.

---
 rtl/fifo_push_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_push_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin burst arbiter for the shared fifo_v3 push port
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [SRC_W-1:0]              fifo_src_o,
  output logic                          fifo_flush_o,
  output logic                          locked_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [SRC_W:0]   NREQ    = (SRC_W + 1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST    = SRC_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] owner;
  logic [CNT_W-1:0] beat_cnt;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  owner_hold;
  logic                  owner_drop;
  logic                  gnt_found;
  logic [SRC_W-1:0]      gnt_idx;
  logic                  do_push;

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] x);
    return (x == LAST) ? '0 : x + SRC_W'(1);
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // The owner keeps the port only while it still presents valid data.
  assign owner_hold = (state == LOCK) &&  req_valid_i[owner];
  assign owner_drop = (state == LOCK) && !req_valid_i[owner];

  // Grant selection: the holding owner wins, otherwise scan from rr_ptr with wrap.
  always_comb begin
    logic [SRC_W:0] k;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    k         = '0;
    if (owner_hold) begin
      gnt_found = 1'b1;
      gnt_idx   = owner;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = {1'b0, rr_ptr} + (SRC_W + 1)'(i);
        if (k >= NREQ) k = k - NREQ;
        if (!gnt_found && req_valid_i[k[SRC_W-1:0]]) begin
          gnt_found = 1'b1;
          gnt_idx   = k[SRC_W-1:0];
        end
      end
    end
  end

  assign do_push      = gnt_found && !fifo_full_i && !flush_i && !rst_i;
  assign fifo_push_o  = do_push;
  assign req_ready_o  = do_push ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign fifo_src_o   = do_push ? gnt_idx : '0;
  assign fifo_data_o  = (gnt_found && !rst_i) ? data_arr[gnt_idx] : '0;
  assign fifo_flush_o = flush_i && !rst_i;
  assign locked_o     = (state == LOCK);

  // Burst/lock bookkeeping; a full FIFO freezes everything so stalls cost no budget.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (flush_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (!fifo_full_i) begin
      if (owner_drop) begin
        state    <= IDLE;
        beat_cnt <= '0;
        rr_ptr   <= next_idx(owner);
      end
      if (do_push) begin
        if (owner_hold) begin
          if (int'(beat_cnt) + 1 < MAX_BURST) begin
            beat_cnt <= beat_cnt + CNT_ONE;
          end else begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= next_idx(owner);
          end
        end else if (MAX_BURST == 1) begin
          rr_ptr <= next_idx(gnt_idx);
        end else begin
          state    <= LOCK;
          owner    <= gnt_idx;
          beat_cnt <= CNT_ONE;
          if (owner_drop) rr_ptr <= next_idx(gnt_idx);
        end
      end
    end
  end

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
  a_push_not_full : assert property (@(posedge clk_i) disable iff (rst_i) fifo_push_o |-> !fifo_full_i);
  a_push_matches  : assert property (@(posedge clk_i) disable iff (rst_i)
                                     fifo_push_o == |(req_ready_o & req_valid_i));

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4 requesters, bursts of 4
  logic         a_rst = 1'b1, a_flush = 1'b0, a_full = 1'b0;
  logic [3:0]   a_valid = '0;
  logic [127:0] a_data = '0;
  logic [3:0]   a_ready;
  logic         a_push, a_flush_o, a_locked;
  logic [31:0]  a_fdata;
  logic [1:0]   a_src;

  // DUT B: 3 requesters, single-beat grants
  logic         b_rst = 1'b1, b_flush = 1'b0, b_full = 1'b0;
  logic [2:0]   b_valid = '0;
  logic [47:0]  b_data = '0;
  logic [2:0]   b_ready;
  logic         b_push, b_flush_o, b_locked;
  logic [15:0]  b_fdata;
  logic [1:0]   b_src;

  fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .req_valid_i(a_valid),
    .req_data_i(a_data), .req_ready_o(a_ready), .fifo_full_i(a_full),
    .fifo_push_o(a_push), .fifo_data_o(a_fdata), .fifo_src_o(a_src),
    .fifo_flush_o(a_flush_o), .locked_o(a_locked));

  fifo_push_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16), .MAX_BURST(1)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .req_valid_i(b_valid),
    .req_data_i(b_data), .req_ready_o(b_ready), .fifo_full_i(b_full),
    .fifo_push_o(b_push), .fifo_data_o(b_fdata), .fifo_src_o(b_src),
    .fifo_flush_o(b_flush_o), .locked_o(b_locked));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: who owns the current burst (-1 = nobody), how many beats it
  // has taken, and where the next fair scan starts.
  typedef struct {
    int owner;
    int taken;
    int ptr;
  } ms_t;

  function automatic ms_t ms_reset();
    ms_t r;
    r.owner = -1; r.taken = 0; r.ptr = 0;
    return r;
  endfunction

  function automatic void model_eval(input int n, input int mb, input ms_t s,
                                     input logic [15:0] v, input logic full,
                                     input logic flush, input logic rst,
                                     output int g, output logic push, output ms_t ns);
    logic dropped;
    g = -1;
    if (s.owner >= 0 && v[s.owner]) g = s.owner;
    else for (int i = 0; i < n; i++) if (g < 0 && v[(s.ptr + i) % n]) g = (s.ptr + i) % n;
    push    = (g >= 0) && !full && !flush && !rst;
    dropped = (s.owner >= 0) && !v[s.owner];
    ns = s;
    if (rst || flush) ns = ms_reset();
    else if (!full) begin
      if (dropped) begin
        ns.owner = -1; ns.taken = 0; ns.ptr = (s.owner + 1) % n;
      end
      if (push) begin
        if (s.owner >= 0 && !dropped) begin
          ns.taken = s.taken + 1;
          if (ns.taken == mb) begin
            ns.owner = -1; ns.taken = 0; ns.ptr = (s.owner + 1) % n;
          end
        end else if (mb == 1) begin
          ns.ptr = (g + 1) % n;
        end else begin
          ns.owner = g; ns.taken = 1;
          if (dropped) ns.ptr = (g + 1) % n;
        end
      end
    end
  endfunction

  ms_t ma = ms_reset(), ma_n = ms_reset();
  ms_t mb = ms_reset(), mb_n = ms_reset();

  // Per-cycle compare of both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    int g;
    logic p;
    model_eval(4, 4, ma, {12'b0, a_valid}, a_full, a_flush, a_rst, g, p, ma_n);
    chk("a_ready", a_ready, p ? (64'd1 << g) : 64'd0);
    chk("a_push", a_push, p);
    chk("a_flush_o", a_flush_o, a_flush && !a_rst);
    chk("a_locked", a_locked, !a_rst && ma.owner >= 0);
    if (p) begin
      chk("a_src", a_src, g);
      chk("a_data", a_fdata, a_data[g*32 +: 32]);
    end
    if (a_rst || a_valid == 0) chk("a_data_idle", a_fdata, 0);

    model_eval(3, 1, mb, {13'b0, b_valid}, b_full, b_flush, b_rst, g, p, mb_n);
    chk("b_ready", b_ready, p ? (64'd1 << g) : 64'd0);
    chk("b_push", b_push, p);
    chk("b_flush_o", b_flush_o, b_flush && !b_rst);
    chk("b_locked", b_locked, 0);
    if (p) begin
      chk("b_src", b_src, g);
      chk("b_data", b_fdata, b_data[g*16 +: 16]);
    end
    if (b_rst || b_valid == 0) chk("b_data_idle", b_fdata, 0);
  end

  // Model state advances on the same edge as the DUTs.
  always @(posedge clk) begin
    ma = ma_n;
    mb = mb_n;
  end

  int a_seq [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  int a_lck [17] = '{0,1,1,1,0,1,1,1,0,1,1,1,0,1,1,1,0};
  int b_seq [5]  = '{0,2,0,2,0};

  logic [3:0] a_rdy_q;
  logic [2:0] b_rdy_q;

  initial begin
    for (int k = 0; k < 4; k++) a_data[k*32 +: 32] = $urandom;
    for (int k = 0; k < 3; k++) b_data[k*16 +: 16] = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("a_reset_push", a_push, 0);
    chk("a_reset_locked", a_locked, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Directed: full-valid rotation on A, alternating pair plus mid-stream reset on B.
    for (int i = 0; i < 17; i++) begin
      a_valid = 4'hf;
      b_valid = 3'b101;
      b_rst   = (i == 5);
      @(negedge clk);
      chk("a_seq_src", a_src, a_seq[i]);
      chk("a_seq_locked", a_locked, a_lck[i]);
      if (i < 5) chk("b_seq_src", b_src, b_seq[i]);
      if (i == 5) chk("b_rst_push", b_push, 0);
      if (i == 6) begin
        chk("b_post_rst_src", b_src, 0);
        chk("b_post_rst_push", b_push, 1);
      end
      @(posedge clk);
      #1;
    end

    // Directed: flush during a burst, then grant restarts at requester 0.
    a_flush = 1'b1;
    @(negedge clk);
    chk("a_flush_lit", a_flush_o, 1);
    chk("a_flush_nopush", a_push, 0);
    @(posedge clk);
    #1;
    a_flush = 1'b0;
    @(negedge clk);
    chk("a_after_flush_src", a_src, 0);
    @(posedge clk);
    #1;

    // Randomised traffic: sticky valids, occasional drops, full, flush and reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_rdy_q = a_ready;
      b_rdy_q = b_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (a_valid[k] && !a_rdy_q[k]) begin
          if ($urandom_range(0, 19) == 0) a_valid[k] = 1'b0;
        end else begin
          a_valid[k] = ($urandom_range(0, 2) != 0);
          a_data[k*32 +: 32] = $urandom;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (b_valid[k] && !b_rdy_q[k]) begin
          if ($urandom_range(0, 19) == 0) b_valid[k] = 1'b0;
        end else begin
          b_valid[k] = ($urandom_range(0, 2) != 0);
          b_data[k*16 +: 16] = 16'($urandom);
        end
      end
      a_full  = ($urandom_range(0, 4) == 0);
      b_full  = ($urandom_range(0, 4) == 0);
      a_flush = ($urandom_range(0, 39) == 0);
      b_flush = ($urandom_range(0, 39) == 0);
      a_rst   = ($urandom_range(0, 299) == 0);
      b_rst   = ($urandom_range(0, 299) == 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
